decode_stage: RTL

- Pipelined, handshaked successor to the single-cycle decode unit. Sits between fetch and execute.
- Decodes RV32I/RV64I OP-IMM, OP (R-type) and LUI into register-file and ALU controls.
- Holds decoded fields in a valid/ready output register.
- Tracks in-flight destination registers in a scoreboard and stalls fetch on RAW/WAW hazards.

---
 rtl/decode_stage.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Pipelined RV32I/RV64I decode stage (OP-IMM, OP, LUI) with a valid/ready output register
// and a destination scoreboard. Optional illegal-instruction trap/halt: DECODE_ILLEGAL_TRAP_EN.

package decode_pkg;
  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_command_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter bit SB_EN    = 1'b1,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [31:0]       fetched_inst,
  output logic              dec_valid,
  input  logic              ex_ready,
  output logic [REG_AW-1:0] reg_rd0_addr,
  output logic [REG_AW-1:0] reg_rd1_addr,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic              reg_rd0_en,
  output logic              reg_rd1_en,
  output logic              reg_wr_en,
  output logic              input_b_is_immediate,
  output logic [XLEN-1:0]   inst_imm,
  output alu_command_t      alu_op,
  output logic              illegal_inst,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rd0_en;
    logic              rd1_en;
    logic              wr_en;
    logic              imm_sel;
    logic [XLEN-1:0]   imm;
    alu_command_t      op;
  } bundle_t;

  function automatic alu_command_t base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] shamt;
  logic       shift_ok;
  logic       legal;
  bundle_t    dec;
  bundle_t    bundle_q;
  logic       dec_valid_q;
  logic       hazard;
  logic       halt;
  logic       accept;

  assign opcode = fetched_inst[6:0];
  assign f3     = fetched_inst[14:12];
  assign f7     = fetched_inst[31:25];

  // On RV64 inst[25] is shamt[5] and only funct6 qualifies the shift; on RV32 it must be 0.
  assign shamt    = {(XLEN == 64) & fetched_inst[25], fetched_inst[24:20]};
  assign shift_ok = (XLEN == 64)
                  ? ((f7[6:1] == 6'b000000) || (f3 == 3'b101 && f7[6:1] == 6'b010000))
                  : ((f7 == 7'b0000000) || (f3 == 3'b101 && f7 == 7'b0100000));

  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    dec.rs1   = REG_AW'(fetched_inst[19:15]);
    dec.rs2   = REG_AW'(fetched_inst[24:20]);
    dec.rd    = REG_AW'(fetched_inst[11:7]);
    dec.op    = ALU_NONE;
    case (opcode)
      OPC_OP_IMM: begin
        legal       = 1'b1;
        dec.rd0_en  = 1'b1;
        dec.wr_en   = 1'b1;
        dec.imm_sel = 1'b1;
        dec.imm     = XLEN'($signed(fetched_inst[31:20]));
        dec.op      = base_op(f3);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm = XLEN'(shamt);
          legal   = shift_ok;
          if (f3 == 3'b101 && fetched_inst[30]) dec.op = ALU_SRA;
        end
      end
      OPC_OP: begin
        dec.rd0_en = 1'b1;
        dec.rd1_en = 1'b1;
        dec.wr_en  = 1'b1;
        if (f7 == 7'b0000000) begin
          legal  = 1'b1;
          dec.op = base_op(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          legal  = 1'b1;
          dec.op = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          legal  = 1'b1;
          dec.op = ALU_SRA;
        end
      end
      OPC_LUI: begin
        legal       = 1'b1;
        dec.wr_en   = 1'b1;
        dec.imm_sel = 1'b1;
        dec.imm     = XLEN'($signed({fetched_inst[31:12], 12'b0}));
        dec.op      = ALU_ADD;
      end
      default: ;
    endcase
    if (dec.rd == '0) dec.wr_en = 1'b0;
    // Illegal encodings still travel down the pipe, but as a bundle that touches nothing.
    if (!legal) begin
      dec    = '0;
      dec.op = ALU_NONE;
    end
  end

  assign fetch_ready = (!dec_valid_q | ex_ready) & !hazard & !halt & !flush;
  assign accept      = fetch_valid & fetch_ready;

  if (SB_EN) begin : g_sb
    logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff;

    // A writeback retiring this cycle already frees its register for the incoming decode.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign busy_eff[r] = busy_q[r] & ~(wb_en & (wb_addr == REG_AW'(r)));
    end

    assign hazard = (dec.rd0_en & busy_eff[dec.rs1])
                  | (dec.rd1_en & busy_eff[dec.rs2])
                  | (dec.wr_en  & busy_eff[dec.rd]);

    always_comb begin
      busy_d = busy_q;
      if (wb_en) busy_d[wb_addr] = 1'b0;
      if (accept && dec.wr_en) busy_d[dec.rd] = 1'b1;
      busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy_q <= '0;
      else          busy_q <= busy_d;
    end
  end else begin : g_nosb
    assign hazard = 1'b0;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic halt_q, halt_d, illegal_q;

  always_comb begin
    halt_d = halt_q;
    if (flush)                halt_d = 1'b0;
    else if (accept && !legal) halt_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      if (accept) illegal_q <= !legal;
    end
  end

  assign halt         = halt_q;
  assign illegal_inst = illegal_q;
`else
  assign halt         = 1'b0;
  assign illegal_inst = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (flush) begin
      dec_valid_q <= 1'b0;
    end else if (accept) begin
      dec_valid_q <= 1'b1;
      bundle_q    <= dec;
    end else if (ex_ready) begin
      dec_valid_q <= 1'b0;
    end
  end

  assign dec_valid            = dec_valid_q;
  assign reg_rd0_addr         = bundle_q.rs1;
  assign reg_rd1_addr         = bundle_q.rs2;
  assign reg_wr_addr          = bundle_q.rd;
  assign reg_rd0_en           = bundle_q.rd0_en;
  assign reg_rd1_en           = bundle_q.rd1_en;
  assign reg_wr_en            = bundle_q.wr_en;
  assign input_b_is_immediate = bundle_q.imm_sel;
  assign inst_imm             = bundle_q.imm;
  assign alu_op               = bundle_q.op;

endmodule
